// File: rtl/strobe_data_tx.sv
// Strobe-qualified parallel transmitter: launches a word, waits SETUP_CYC, strobes for HOLD_CYC, then idles GAP_CYC.
// Optional tx_parity output (even parity of the launched word) when STROBE_TX_PARITY_EN is defined.
module strobe_data_tx #(
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_strobe,
    output logic              busy,
    output logic              done
`ifdef STROBE_TX_PARITY_EN
    ,
    output logic              tx_parity
`endif
);

    localparam int MAX_AB  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_AB > GAP_CYC) ? MAX_AB : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    if (SETUP_CYC < 1) begin : g_bad_setup
        $error("strobe_data_tx: SETUP_CYC must be >= 1");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("strobe_data_tx: HOLD_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   r_tx_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic                r_tx_strobe;
    logic                w_strobe_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tx_data   <= '0;
            r_tx_strobe <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tx_data   <= w_data_nxt;
            r_tx_strobe <= w_strobe_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_tx_data;
        w_strobe_nxt = r_tx_strobe;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_cnt_nxt   = SETUP_LD;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_strobe_nxt = 1'b1;
                    w_cnt_nxt    = HOLD_LD;
                    w_state_nxt  = S_STROBE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_STROBE: begin
                if (w_cnt_zero) begin
                    w_strobe_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    // With no gap the block re-arms directly from the strobe's falling edge.
                    if (GAP_CYC > 0) begin
                        w_cnt_nxt   = GAP_LD;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef STROBE_TX_PARITY_EN
    logic r_tx_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_parity <= 1'b0;
        end else if ((r_state == S_IDLE) && in_valid) begin
            r_tx_parity <= ^in_data;
        end
    end

    assign tx_parity = r_tx_parity;
`endif

    // Gated by rst so upstream never sees ready while the block is held in reset.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign tx_data   = r_tx_data;
    assign tx_strobe = r_tx_strobe;
    assign done      = r_done;

endmodule

// File: tb/tb_strobe_data_tx.sv
// Directed bench for strobe_data_tx: default-parameter instance plus a GAP_CYC=0 instance.
// Parity checks are compiled in when STROBE_TX_PARITY_EN is defined.
module tb_strobe_data_tx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       busy;
    logic       done;

    logic       in_valid0;
    logic       in_ready0;
    logic [7:0] in_data0;
    logic [7:0] tx_data0;
    logic       tx_strobe0;
    logic       busy0;
    logic       done0;
`ifdef STROBE_TX_PARITY_EN
    logic       tx_parity;
    logic       tx_parity0;
`endif

    int n_cmp;
    int n_err;

    strobe_data_tx #(
        .DATA_W   (8),
        .SETUP_CYC(2),
        .HOLD_CYC (2),
        .GAP_CYC  (1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx_data  (tx_data),
        .tx_strobe(tx_strobe),
        .busy     (busy),
        .done     (done)
`ifdef STROBE_TX_PARITY_EN
        ,
        .tx_parity(tx_parity)
`endif
    );

    strobe_data_tx #(
        .DATA_W   (8),
        .SETUP_CYC(2),
        .HOLD_CYC (2),
        .GAP_CYC  (0)
    ) u_dut_gap0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid0),
        .in_ready (in_ready0),
        .in_data  (in_data0),
        .tx_data  (tx_data0),
        .tx_strobe(tx_strobe0),
        .busy     (busy0),
        .done     (done0)
`ifdef STROBE_TX_PARITY_EN
        ,
        .tx_parity(tx_parity0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] exp_stb;
        logic [5:0] exp_done;
        logic [5:0] exp_rdy;
        logic [4:0] g0_stb;
        logic [4:0] g0_done;
        logic [4:0] g0_rdy;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_valid0 = 1'b0;
        in_data0  = 8'h00;

        // Reset held for two edges.
        tick();
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_strobe", 32'(tx_strobe), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        tick();
        check("rst_ready2", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(in_ready), 32'h1);
        check("idle_tx_data", 32'(tx_data), 32'h00);

        // Single word 0xA5; expectations per edge 0..5 indexed by bit.
        exp_stb  = 6'b001100;
        exp_done = 6'b010000;
        exp_rdy  = 6'b100000;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("single_tx_data", 32'(tx_data), 32'hA5);
        check("single_busy", 32'(busy), 32'h1);
`ifdef STROBE_TX_PARITY_EN
        check("parity_a5", 32'(tx_parity), 32'h0);
`endif
        for (int e = 0; e < 6; e++) begin
            if (e > 0) tick();
            check($sformatf("single_strobe_e%0d", e), 32'(tx_strobe), 32'(exp_stb[e]));
            check($sformatf("single_done_e%0d", e), 32'(done), 32'(exp_done[e]));
            check($sformatf("single_ready_e%0d", e), 32'(in_ready), 32'(exp_rdy[e]));
        end
        check("single_hold_data", 32'(tx_data), 32'hA5);
        check("single_idle_busy", 32'(busy), 32'h0);

        // Back-to-back: 0x3C accepted at edge 0, 0xC3 at edge 6.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        check("b2b_first_data", 32'(tx_data), 32'h3C);
        in_data = 8'hC3;
        for (int e = 1; e < 6; e++) begin
            tick();
            check($sformatf("b2b_hold_e%0d", e), 32'(tx_data), 32'h3C);
            check($sformatf("b2b_done_e%0d", e), 32'(done), 32'(e == 4));
        end
        check("b2b_ready_e5", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("b2b_second_data", 32'(tx_data), 32'hC3);
        check("b2b_ready_e6", 32'(in_ready), 32'h0);
        check("b2b_done_e6", 32'(done), 32'h0);
        for (int e = 7; e < 12; e++) begin
            tick();
            check($sformatf("b2b_done_e%0d", e), 32'(done), 32'(e == 10));
        end

        // Toggling in_valid with 0xFF while busy must not be accepted.
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_data = 8'hFF;
        for (int e = 1; e < 5; e++) begin
            in_valid = ((e % 2) == 1);
            tick();
            check($sformatf("busy_data_e%0d", e), 32'(tx_data), 32'h3C);
            check($sformatf("busy_ready_e%0d", e), 32'(in_ready), 32'h0);
        end
        in_valid = 1'b0;
        tick();
        check("busy_final_data", 32'(tx_data), 32'h3C);
        check("busy_final_ready", 32'(in_ready), 32'h1);

        // Reset asserted while strobe is high.
        in_data  = 8'h96;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_strobe_high", 32'(tx_strobe), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_strobe", 32'(tx_strobe), 32'h0);
        check("mid_rst_data", 32'(tx_data), 32'h00);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'h1);
        tick();
        check("post_rst_no_done", 32'(done), 32'h0);

        // Fresh transfer after the truncated one.
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fresh_data", 32'(tx_data), 32'h11);
        tick();
        check("fresh_strobe_e1", 32'(tx_strobe), 32'h0);
        tick();
        check("fresh_strobe_e2", 32'(tx_strobe), 32'h1);
        tick();
        tick();
        check("fresh_done_e4", 32'(done), 32'h1);
        check("fresh_strobe_e4", 32'(tx_strobe), 32'h0);
        tick();
        check("fresh_ready_e5", 32'(in_ready), 32'h1);

`ifdef STROBE_TX_PARITY_EN
        in_data  = 8'h07;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("parity_07", 32'(tx_parity), 32'h1);
        for (int e = 1; e < 6; e++) tick();
        check("parity_07_held", 32'(tx_parity), 32'h1);
`endif

        // GAP_CYC=0 instance: strobe falls and ready returns after edge 4.
        g0_stb    = 5'b01100;
        g0_done   = 5'b10000;
        g0_rdy    = 5'b10000;
        in_data0  = 8'h5A;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        check("gap0_data", 32'(tx_data0), 32'h5A);
        check("gap0_ready_e0", 32'(in_ready0), 32'h0);
        for (int e = 1; e < 5; e++) begin
            tick();
            check($sformatf("gap0_strobe_e%0d", e), 32'(tx_strobe0), 32'(g0_stb[e]));
            check($sformatf("gap0_done_e%0d", e), 32'(done0), 32'(g0_done[e]));
            check($sformatf("gap0_ready_e%0d", e), 32'(in_ready0), 32'(g0_rdy[e]));
        end
        check("gap0_busy_e4", 32'(busy0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
